// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared constants, font table and sizing helper for the hex display scanner
package hex_display_pkg;

    typedef logic [6:0] seg_t;

    // Segment pattern of a dark digit before polarity is applied.
    localparam seg_t SEG_BLANK_HI = 7'h00;

    localparam int MAX_DIGITS = 8;

    // Active-high hex glyphs, bit0 = a .. bit6 = g.
    localparam seg_t FONT_HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_seg_font.sv
// rtl/hex_seg_font.sv - combinational nibble to active-high seven-segment glyph
// Ports: nibble (4-bit hex digit in), seg_hi (7-bit active-high segments out, bit0=a).
module hex_seg_font
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_hi
);

    assign seg_hi = FONT_HI[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - time-multiplexed N-digit hex display driver with frame-aligned double buffer
// Ports: clk, resetn (async active-low), load/value/blank_mask (shadow capture), lz_suppress (live),
//        seg (shared segments), dig_en (one-hot digit enable), frame_done (pulse per frame), pending (shadow full).
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = clog2_min1(NUM_DIGITS);

    localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? ~SEG_BLANK_HI : SEG_BLANK_HI;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_next;
    logic                    tick;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] active_value;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   active_blank;
    logic [NUM_DIGITS-1:0]   shadow_blank;

    logic [NUM_DIGITS:0]     upper_zero;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic                    cur_lz;
    logic [6:0]              font_seg;
    logic [6:0]              slot_seg_hi;
    logic [6:0]              slot_seg;
    logic [NUM_DIGITS-1:0]   slot_dig_hi;
    logic [NUM_DIGITS-1:0]   slot_dig;

    assign tick     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_next = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    // The tick that opens the last digit's slot closes the frame; the next slot reads the new buffer.
    assign wrap     = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    // upper_zero[d] is set when nibbles d..NUM_DIGITS-1 of the shown value are all zero.
    always_comb begin
        upper_zero             = '0;
        upper_zero[NUM_DIGITS] = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            upper_zero[d] = upper_zero[d+1] && (active_value[4*d +: 4] == 4'h0);
        end
    end

    always_comb begin
        cur_nib     = '0;
        cur_blank   = 1'b0;
        cur_lz      = 1'b0;
        slot_dig_hi = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
                cur_nib        = active_value[4*d +: 4];
                cur_blank      = active_blank[d];
                cur_lz         = (d != 0) && upper_zero[d];
                slot_dig_hi[d] = 1'b1;
            end
        end
    end

    hex_seg_font u_font (
        .nibble (cur_nib),
        .seg_hi (font_seg)
    );

    always_comb begin
        slot_seg_hi = (cur_blank || (lz_suppress && cur_lz)) ? SEG_BLANK_HI : font_seg;
        slot_seg    = (SEG_ACT_LOW != 0) ? ~slot_seg_hi : slot_seg_hi;
        slot_dig    = (DIG_ACT_LOW != 0) ? ~slot_dig_hi : slot_dig_hi;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt          <= '0;
            idx          <= '0;
            active_value <= '0;
            shadow_value <= '0;
            active_blank <= '0;
            shadow_blank <= '0;
            pending      <= 1'b0;
            frame_done   <= 1'b0;
            seg          <= SEG_OFF;
            dig_en       <= DIG_OFF;
        end else begin
            cnt        <= tick ? '0 : cnt + CNT_W'(1);
            frame_done <= wrap;

            if (tick) begin
                idx    <= idx_next;
                seg    <= slot_seg;
                dig_en <= slot_dig;
            end

            if (wrap) begin
                // A load landing on the wrap cycle bypasses the shadow entirely.
                if (pending || load) begin
                    active_value <= load ? value      : shadow_value;
                    active_blank <= load ? blank_mask : shadow_blank;
                end
                pending <= 1'b0;
            end else if (load) begin
                shadow_value <= value;
                shadow_blank <= blank_mask;
                pending      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - self-checking bench for hex_display_scanner
module tb_hex_display_scanner;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  bmask = '0;
    logic        lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_done;
    logic        pending;

    always #5 clk = ~clk;

    hex_display_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .SEG_ACT_LOW (1),
        .DIG_ACT_LOW (1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .load        (load),
        .value       (value),
        .blank_mask  (bmask),
        .lz_suppress (lz),
        .seg         (seg),
        .dig_en      (dig_en),
        .frame_done  (frame_done),
        .pending     (pending)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges counted since reset release; slot s (every DIV edges) shows digit (s-1) mod N.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int          e;
    logic [15:0] m_val, s_val;
    logic [3:0]  m_bm, s_bm;
    bit          m_pend;
    logic [6:0]  x_seg;
    logic [3:0]  x_dig;
    bit          x_fd;
    bit          saw_one;

    function automatic logic [6:0] model_seg(int d, logic [15:0] v, logic [3:0] bm, bit z);
        logic [3:0] nib;
        bit dark;
        nib  = v[4*d +: 4];
        dark = bm[d] || (z && d > 0 && (v >> (4*d)) == 16'h0);
        return dark ? 7'h7F : ~GLYPH[nib];
    endfunction

    task automatic model_reset();
        e = 0; m_val = '0; s_val = '0; m_bm = '0; s_bm = '0; m_pend = 0;
        x_seg = 7'h7F; x_dig = 4'hF; x_fd = 0;
    endtask

    task automatic model_edge();
        int d;
        bit wr;
        logic [3:0] one;
        e++;
        wr = 0;
        x_fd = 0;
        if (e % DIV == 0) begin
            d     = ((e / DIV) - 1) % N;
            x_seg = model_seg(d, m_val, m_bm, lz);
            one   = 4'b0001 << d;
            x_dig = ~one;
            wr    = (d == N - 1);
        end
        if (wr) begin
            x_fd = 1;
            if (load) begin
                m_val = value; m_bm = bmask;
            end else if (m_pend) begin
                m_val = s_val; m_bm = s_bm;
            end
            m_pend = 0;
        end else if (load) begin
            s_val = value; s_bm = bmask; m_pend = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (seg == 7'h79) saw_one = 1;
        chk("seg", 32'(seg), 32'(x_seg));
        chk("dig_en", 32'(dig_en), 32'(x_dig));
        chk("frame_done", 32'(frame_done), 32'(x_fd));
        chk("pending", 32'(pending), 32'(m_pend));
    endtask

    // Waits for a frame wrap, then records the segments of every digit over the following frame.
    task automatic capture_frame(output logic [27:0] got, output bit ok);
        logic [3:0] one;
        got = '1;
        ok  = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (frame_done) ok = 1;
        end
        if (!ok) return;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            for (int d = 0; d < N; d++) begin
                one = 4'b0001 << d;
                if (dig_en == ~one) got[7*d +: 7] = seg;
            end
            if (frame_done) ok = 1;
        end
    endtask

    typedef struct {
        logic [15:0] v;
        logic [3:0]  bm;
        bit          z;
        logic [27:0] exp;   // {d3, d2, d1, d0} active-low segments
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [27:0] got;
        bit ok;

        vecs[0] = '{16'h1A2F, 4'b0000, 0, {7'h79, 7'h08, 7'h24, 7'h0E}};
        vecs[1] = '{16'h0005, 4'b0000, 1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
        vecs[2] = '{16'h0005, 4'b0000, 0, {7'h40, 7'h40, 7'h40, 7'h12}};
        vecs[3] = '{16'h0100, 4'b0000, 1, {7'h7F, 7'h79, 7'h40, 7'h40}};
        vecs[4] = '{16'h1A2F, 4'b0101, 0, {7'h79, 7'h7F, 7'h24, 7'h7F}};
        vecs[5] = '{16'h0000, 4'b0000, 1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[6] = '{16'h0000, 4'b0000, 0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[7] = '{16'hC0DE, 4'b0000, 1, {7'h46, 7'h40, 7'h21, 7'h06}};

        // Reset state
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dig_en", 32'(dig_en), 32'hF);
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_frame_done", 32'(frame_done), 32'h0);
        resetn = 1'b1;
        repeat (3) step();
        chk("dark_before_tick", 32'(seg), 32'h7F);
        step();
        chk("first_digit_seg", 32'(seg), 32'h40);
        chk("first_digit_en", 32'(dig_en), 32'hE);

        // Table-driven vectors
        foreach (vecs[i]) begin
            value = vecs[i].v; bmask = vecs[i].bm; lz = vecs[i].z; load = 1'b1;
            step();
            load = 1'b0;
            capture_frame(got, ok);
            chk("vec_timeout", 32'(ok), 32'h1);
            chk($sformatf("vec%0d_digits", i), 32'(got), 32'(vecs[i].exp));
        end
        lz = 1'b0;

        // Two loads inside one frame: the later one wins, the earlier is never shown
        capture_frame(got, ok);
        value = 16'h1111; load = 1'b1; step();
        value = 16'h2222; step();
        load = 1'b0;
        chk("double_load_pending", 32'(pending), 32'h1);
        saw_one = 0;
        capture_frame(got, ok);
        chk("double_load_timeout", 32'(ok), 32'h1);
        chk("double_load_digits", 32'(got), {4'h0, {4{7'h24}}});
        chk("first_load_never_shown", 32'(saw_one), 32'h0);

        // Load landing exactly on the frame-wrap cycle
        for (int i = 0; i < 20 && ((e + 1) % (DIV * N) != 0); i++) step();
        value = 16'h8888; load = 1'b1;
        step();
        load = 1'b0;
        chk("wrap_load_frame_done", 32'(frame_done), 32'h1);
        chk("wrap_load_pending", 32'(pending), 32'h0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (dig_en == 4'hE) ok = 1;
        end
        chk("wrap_load_digit0", 32'(seg), 32'h00);
        capture_frame(got, ok);
        chk("wrap_load_digits", 32'(got), 28'h0);

        // Asynchronous reset mid-frame with data pending
        repeat (5) step();
        value = 16'h5555; load = 1'b1; step();
        load = 1'b0;
        chk("pre_reset_pending", 32'(pending), 32'h1);
        step();
        #1 resetn = 1'b0;
        #1;
        chk("async_reset_seg", 32'(seg), 32'h7F);
        chk("async_reset_dig_en", 32'(dig_en), 32'hF);
        chk("async_reset_pending", 32'(pending), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        capture_frame(got, ok);
        chk("post_reset_timeout", 32'(ok), 32'h1);
        chk("post_reset_digits", 32'(got), {4'h0, {4{7'h40}}});

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            load  = ($urandom_range(0, 11) == 0);
            value = 16'($urandom);
            bmask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 49) == 0) lz = ~lz;
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            step();
        end
        load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
